// File: rtl/prog_mem_pkg.sv
// Shared types and default geometry for the program memory controller.
package prog_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

endpackage

// File: rtl/prog_mem_array.sv
// DEPTH x DATA_W storage: one write port, one registered read port.
module prog_mem_array
  import prog_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register holds its last value when no read is issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/program_mem_ctrl.sv
// Program memory controller: sequential load from address 0, then single-cycle-latency fetch.
module program_mem_ctrl
  import prog_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  output logic              mem_ready
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              wr_en;
  logic              rd_en;
  logic              load_done_d;
  logic              fetch_err_d;

  // Next state, write pointer and pulse outputs.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    load_done_d = 1'b0;
    fetch_err_d = 1'b0;

    if (fetch_req) begin
      if (state_q == RUN) begin
        rd_en = 1'b1;
      end else begin
        fetch_err_d = 1'b1;
      end
    end

    // A load_start beats a concurrent load word: the word is dropped.
    if (load_start) begin
      state_d = LOAD;
      ptr_d   = '0;
    end else if (state_q == LOAD && load_valid) begin
      wr_en = 1'b1;
      ptr_d = ptr_q + ADDR_W'(1);
      if (ptr_q == LAST_ADDR) begin
        state_d     = RUN;
        load_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      load_ready  <= 1'b0;
      load_done   <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      mem_ready   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      load_ready  <= (state_d == LOAD);
      load_done   <= load_done_d;
      fetch_valid <= rd_en;
      fetch_err   <= fetch_err_d;
      mem_ready   <= (state_d == RUN);
    end
  end

  prog_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en && rst_n),
    .wr_addr (ptr_q),
    .wr_data (load_data),
    .rd_en   (rd_en),
    .rd_addr (fetch_addr),
    .rd_data (fetch_data)
  );

endmodule

// File: tb/tb_program_mem_ctrl.sv
// Directed bench for program_mem_ctrl with a fetch scoreboard and a small behavioural model.
module tb_program_mem_ctrl;

  localparam int unsigned AW    = 3;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;

  logic          clk;
  logic          rst_n;
  logic          load_start;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic          load_done;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_valid;
  logic [DW-1:0] fetch_data;
  logic          fetch_err;
  logic          mem_ready;

  program_mem_ctrl #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_ready  (load_ready),
    .load_done   (load_done),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .fetch_err   (fetch_err),
    .mem_ready   (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: 0 idle, 1 load, 2 run
  int            mst;
  logic [AW-1:0] mptr;
  logic [DW-1:0] mmem [DEPTH];
  logic          exp_done;
  logic          exp_err;
  logic [DW-1:0] last_data;
  logic [DW-1:0] sb [$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pattern(input int k, input int i);
    logic [DW-1:0] w;
    case (k)
      0: begin
        if (i == 0)      w = 32'h1100_0014;
        else if (i == 1) w = 32'h1200_0020;
        else if (i == 2) w = 32'h2120_0000;
        else             w = 32'hF100_0000;
      end
      1:       w = 32'hA000_0000 + DW'(i);
      2:       w = 32'hB000_0000 + DW'(i);
      default: w = 32'hC000_0000 + DW'(i);
    endcase
    return w;
  endfunction

  task automatic step_check();
    logic [DW-1:0] e;
    chk("load_ready", DW'(load_ready), DW'(mst == 1));
    chk("mem_ready",  DW'(mem_ready),  DW'(mst == 2));
    chk("load_done",  DW'(load_done),  DW'(exp_done));
    chk("fetch_err",  DW'(fetch_err),  DW'(exp_err));
    chk("ptr",        DW'(u_dut.ptr_q), DW'(mptr));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("fetch_valid", DW'(fetch_valid), 32'd1);
      chk("fetch_data",  fetch_data, e);
      last_data = e;
    end else begin
      chk("fetch_valid_idle", DW'(fetch_valid), 32'd0);
      chk("fetch_data_hold",  fetch_data, last_data);
    end
  endtask

  task automatic cycle(input logic ls, input logic lv, input logic [DW-1:0] ld,
                       input logic fr, input logic [AW-1:0] fa);
    load_start = ls;
    load_valid = lv;
    load_data  = ld;
    fetch_req  = fr;
    fetch_addr = fa;
    exp_done   = 1'b0;
    exp_err    = 1'b0;
    if (fr) begin
      if (mst == 2) sb.push_back(mmem[fa]);
      else          exp_err = 1'b1;
    end
    if (ls) begin
      mst  = 1;
      mptr = '0;
    end else if (mst == 1 && lv) begin
      mmem[mptr] = ld;
      if (mptr == AW'(DEPTH - 1)) begin
        mst      = 2;
        exp_done = 1'b1;
      end
      mptr = mptr + AW'(1);
    end
    @(posedge clk);
    #1;
    step_check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    @(posedge clk);
    #1;
    mst       = 0;
    mptr      = '0;
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    last_data = '0;
    sb.delete();
    rst_n = 1'b1;
    step_check();
  endtask

  task automatic load_all(input int k);
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < int'(DEPTH); i++) cycle(1'b0, 1'b1, pattern(k, i), 1'b0, '0);
  endtask

  task automatic fetch_all();
    for (int i = 0; i < int'(DEPTH); i++) cycle(1'b0, 1'b0, '0, 1'b1, AW'(i));
    idle(2);
  endtask

  initial begin
    mst       = 0;
    mptr      = '0;
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    last_data = '0;
    do_reset();
    chk("rst_fetch_data", fetch_data, 32'd0);
    idle(1);

    // Fetch while idle is rejected
    cycle(1'b0, 1'b0, '0, 1'b1, '0);
    chk("idle_fetch_err", DW'(fetch_err), 32'd1);
    chk("idle_mem_ready", DW'(mem_ready), 32'd0);
    idle(1);

    // Full load, then back-to-back fetches
    load_all(0);
    chk("load_done_pulse", DW'(load_done), 32'd1);
    chk("run_mem_ready",   DW'(mem_ready), 32'd1);
    idle(1);
    fetch_all();

    // Gapped load, fetch rejected, then load_start beats a concurrent word
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    cycle(1'b0, 1'b1, 32'hD000_0000, 1'b0, '0);
    cycle(1'b0, 1'b0, 32'hD000_0001, 1'b1, 3'd3);
    chk("load_fetch_err", DW'(fetch_err), 32'd1);
    cycle(1'b0, 1'b1, 32'hD000_0002, 1'b0, '0);
    chk("gapped_ptr",   DW'(u_dut.ptr_q), 32'd2);
    chk("gapped_ready", DW'(load_ready), 32'd1);
    cycle(1'b1, 1'b1, 32'hEEEE_EEEE, 1'b0, '0);
    chk("restart_ptr", DW'(u_dut.ptr_q), 32'd0);
    for (int i = 0; i < int'(DEPTH); i++) cycle(1'b0, 1'b1, pattern(0, i), 1'b0, '0);
    idle(1);

    // Fetch and load_start together in RUN
    cycle(1'b1, 1'b0, '0, 1'b1, 3'd2);
    chk("overlap_data",       fetch_data, 32'h2120_0000);
    chk("overlap_mem_ready",  DW'(mem_ready), 32'd0);
    chk("overlap_load_ready", DW'(load_ready), 32'd1);
    for (int i = 0; i < int'(DEPTH); i++) cycle(1'b0, 1'b1, pattern(1, i), 1'b0, '0);
    cycle(1'b0, 1'b0, '0, 1'b1, 3'd2);
    chk("reload_addr2", fetch_data, 32'hA000_0002);
    idle(1);
    fetch_all();

    // Reset mid-load aborts; memory keeps contents
    cycle(1'b1, 1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, pattern(2, i), 1'b0, '0);
    do_reset();
    chk("mem_keep_1", u_dut.u_mem.mem[1], 32'hB000_0001);
    chk("mem_keep_5", u_dut.u_mem.mem[5], 32'hA000_0005);
    cycle(1'b0, 1'b0, '0, 1'b1, 3'd4);
    chk("post_rst_fetch_err", DW'(fetch_err), 32'd1);
    idle(1);
    load_all(3);
    idle(1);
    fetch_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_mem_ctrl.md
PROGRAM_MEM_CTRL -- requirements
Module: program_mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 3, word-address width; DEPTH = 2**ADDR_W.
REQ-002 Parameter DATA_W, default 32, instruction word width.
REQ-003 Port clk  input  1  single clock; all logic on rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port load_start  input  1  pulse: begin (re)load from address 0.
REQ-006 Port load_valid  input  1  load word present on load_data.
REQ-007 Port load_data  input  DATA_W  word to write.
REQ-008 Port load_ready  output  1  high while in LOAD; word accepted when load_valid && load_ready.
REQ-009 Port load_done  output  1  one-cycle pulse on LOAD->RUN.
REQ-010 Port fetch_req  input  1  read request.
REQ-011 Port fetch_addr  input  ADDR_W  read word address.
REQ-012 Port fetch_valid  output  1  fetch_data valid this cycle.
REQ-013 Port fetch_data  output  DATA_W  read word.
REQ-014 Port fetch_err  output  1  one-cycle pulse: fetch_req rejected.
REQ-015 Port mem_ready  output  1  high while in RUN.

Function
REQ-016 States IDLE, LOAD, RUN; reset state IDLE.
REQ-017 IDLE/RUN/LOAD -> LOAD on load_start; write pointer set to 0 on that edge.
REQ-018 LOAD: each accepted word written at pointer, pointer +1; load_valid low -> no write, no advance.
REQ-019 LOAD -> RUN on the edge accepting the word at address DEPTH-1; pointer wraps to 0; load_done high the following cycle only.
REQ-020 load_start with load_valid same cycle: load_start wins, word discarded, pointer 0.
REQ-021 RUN: fetch_req at edge N -> fetch_valid=1, fetch_data=mem[fetch_addr] during cycle N+1 (latency 1); back-to-back requests every cycle supported.
REQ-022 fetch_req in IDLE or LOAD: no read, fetch_valid stays 0, fetch_err high next cycle only.
REQ-023 fetch_req and load_start same cycle in RUN: fetch served normally, LOAD entered same edge.
REQ-024 fetch_valid low -> fetch_data holds last read value.
REQ-025 Memory contents not altered by any fetch, nor in IDLE/RUN.

Reset
REQ-026 rst_n low at an edge: state IDLE, pointer 0, load_ready 0, load_done 0, fetch_valid 0, fetch_err 0, fetch_data 0, mem_ready 0.
REQ-027 Reset mid-LOAD aborts load; a new load_start required before fetches accepted.
REQ-028 Memory array not cleared by reset.

Structure
REQ-029 Shared package prog_mem_pkg holds state enum (IDLE/LOAD/RUN) and default ADDR_W/DATA_W constants.
REQ-030 Storage in sub-module prog_mem_array: 1 write port, 1 registered read port, DEPTH x DATA_W.

Verification
REQ-031 Reset, then fetch_req addr 0 -> fetch_err pulse next cycle, fetch_valid 0, mem_ready 0.
REQ-032 load_start, then 8 words 0x11000014,0x12000020,0x21200000,0xF1000000 x5 with load_valid continuous -> load_done one pulse after 8th word, mem_ready 1; fetch addr 0..7 back-to-back -> same words, each 1 cycle after request.
REQ-033 LOAD with load_valid toggling 1,0,1 -> only 2 words written, pointer 2, still LOAD; fetch during this -> fetch_err.
REQ-034 In RUN, fetch_req addr 2 with load_start same cycle -> fetch_data 0x21200000 next cycle, mem_ready 0, load_ready 1; reload 8 words 0xA0000000+i -> addr 2 reads 0xA0000002.
REQ-035 rst_n low after 3 loaded words -> IDLE, all outputs 0; fetch -> fetch_err; full reload -> previous unwritten addresses retain old contents only where overwritten words absent.
